// File: rtl/app_read_arbiter_if.sv
// app_read_arbiter_if
//   Bundles the DSP read strobe, the App read-data sources and the arbitrated
//   read-bus outputs of app_read_arbiter.
//
//   master : the arbiter side. It receives the strobe, the App words and the
//            claims, and drives the arbitrated word, the enable and the status.
//   slave  : the surrounding system. It drives the strobe, the App words and
//            the claims, and receives the arbitrated word and the status.
//
//   read_qualified   decoded DSP read strobe
//   db_out_app       App read data, App i at bits [16i+15:16i]
//   data_avail_app   App i claims the current address when bit i is high
//   clear_collision  single-cycle pulse that clears the collision status
//   db_out           arbitrated read word
//   db_out_en        bus driver enable
//   read_done        one-cycle pulse when a drive finishes
//   no_responder     one-cycle pulse when no App claimed a read
//   collision        sticky multiple-claim flag
//   collision_count  saturating count of collided reads
interface app_read_arbiter_if #(
  parameter int NUM_APPS = 4
);
  logic                    read_qualified;
  logic [16*NUM_APPS-1:0]  db_out_app;
  logic [NUM_APPS-1:0]     data_avail_app;
  logic                    clear_collision;
  logic [15:0]             db_out;
  logic                    db_out_en;
  logic                    read_done;
  logic                    no_responder;
  logic                    collision;
  logic [7:0]              collision_count;

  modport master (
    input  read_qualified,
    input  db_out_app,
    input  data_avail_app,
    input  clear_collision,
    output db_out,
    output db_out_en,
    output read_done,
    output no_responder,
    output collision,
    output collision_count
  );

  modport slave (
    output read_qualified,
    output db_out_app,
    output data_avail_app,
    output clear_collision,
    input  db_out,
    input  db_out_en,
    input  read_done,
    input  no_responder,
    input  collision,
    input  collision_count
  );
endinterface

// File: rtl/app_read_arbiter.sv
// app_read_arbiter
//   Arbitrates the read data of NUM_APPS Apps onto the DSP read bus. A rising
//   read strobe opens a read; after one WAIT cycle the lowest-index claiming
//   App's word is latched and driven for at least HOLD_CYCLES cycles (longer
//   while the strobe stays high), followed by TURN_CYCLES bus-release cycles.
//   Unclaimed reads return 16'hFFFF; multiply-claimed reads are flagged.
//
//   xclk    system clock, rising edge
//   reset   synchronous, active-high reset
//   bus     app_read_arbiter_if.master: strobe, App words/claims,
//           collision clear, arbitrated word, enable and status outputs
//
//   NUM_APPS     number of App sources
//   HOLD_CYCLES  minimum drive length in cycles (1..15)
//   TURN_CYCLES  bus-release length in cycles (1..15)
module app_read_arbiter #(
  parameter int NUM_APPS    = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int TURN_CYCLES = 1
) (
  input  logic               xclk,
  input  logic               reset,
  app_read_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRIVE,
    TURN
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

  state_t                  state;
  state_t                  next_state;
  logic                    rq_d;
  logic                    pending;
  logic [3:0]              hold_cnt;
  logic [3:0]              turn_cnt;
  logic                    read_start;
  logic                    latch_now;
  logic                    multi_claim;
  logic [15:0]             win_word;
  logic [NUM_APPS-1:0]     avail;
  logic [16*NUM_APPS-1:0]  app_words;

  logic [15:0]             db_out_q;
  logic                    db_out_en_q;
  logic                    read_done_q;
  logic                    no_responder_q;
  logic                    collision_q;
  logic [7:0]              collision_count_q;

  assign avail      = bus.data_avail_app;
  assign app_words  = bus.db_out_app;
  assign read_start = bus.read_qualified & ~rq_d;
  assign latch_now  = (state == WAIT) && bus.read_qualified;

  // Clearing the lowest set bit leaves something only if two or more Apps claim.
  assign multi_claim = |(avail & (avail - NUM_APPS'(1)));

  // Scan from the top down so the lowest-index claimer is the last writer.
  always_comb begin
    win_word = 16'hFFFF;
    for (int i = NUM_APPS - 1; i >= 0; i--) begin
      if (avail[i]) begin
        win_word = app_words[16*i +: 16];
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (read_start || pending) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        next_state = bus.read_qualified ? DRIVE : IDLE;
      end
      DRIVE: begin
        if ((hold_cnt >= HOLD_LAST) && !bus.read_qualified) begin
          next_state = TURN;
        end
      end
      TURN: begin
        if (turn_cnt >= TURN_LAST) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so db_out_en rises on the same
  // edge that enters DRIVE and falls on the edge that leaves it.
  always_ff @(posedge xclk) begin
    if (reset) begin
      state             <= IDLE;
      rq_d              <= 1'b0;
      pending           <= 1'b0;
      hold_cnt          <= 4'd0;
      turn_cnt          <= 4'd0;
      db_out_q          <= 16'h0000;
      db_out_en_q       <= 1'b0;
      read_done_q       <= 1'b0;
      no_responder_q    <= 1'b0;
      collision_q       <= 1'b0;
      collision_count_q <= 8'd0;
    end else begin
      state <= next_state;
      rq_d  <= bus.read_qualified;

      // A start seen in IDLE is taken directly; elsewhere it is remembered once.
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (read_start) begin
        pending <= 1'b1;
      end

      // Counters saturate so a very long strobe cannot wrap the hold count.
      if (state == DRIVE) begin
        if (hold_cnt != 4'hF) begin
          hold_cnt <= hold_cnt + 4'd1;
        end
      end else begin
        hold_cnt <= 4'd0;
      end

      if (state == TURN) begin
        if (turn_cnt != 4'hF) begin
          turn_cnt <= turn_cnt + 4'd1;
        end
      end else begin
        turn_cnt <= 4'd0;
      end

      db_out_en_q    <= (next_state == DRIVE);
      read_done_q    <= (state == DRIVE) && (next_state == TURN);
      no_responder_q <= latch_now && (avail == '0);

      if (latch_now) begin
        db_out_q <= win_word;
      end

      // A clear on the same edge as a collision wins.
      if (bus.clear_collision) begin
        collision_q       <= 1'b0;
        collision_count_q <= 8'd0;
      end else if (latch_now && multi_claim) begin
        collision_q <= 1'b1;
        if (collision_count_q != 8'hFF) begin
          collision_count_q <= collision_count_q + 8'd1;
        end
      end
    end
  end

  assign bus.db_out          = db_out_q;
  assign bus.db_out_en       = db_out_en_q;
  assign bus.read_done       = read_done_q;
  assign bus.no_responder    = no_responder_q;
  assign bus.collision       = collision_q;
  assign bus.collision_count = collision_count_q;

endmodule

// File: tb/tb_app_read_arbiter.sv
// tb_app_read_arbiter
//   Directed bench for app_read_arbiter with the default parameters
//   (4 Apps, hold 3, turn 1). Each read is run over a fixed window of edges;
//   the enable, read_done and no_responder outputs are recorded as bit masks
//   (bit k = value just after edge k, edge 0 being the read-start edge) and
//   compared against hand-computed masks.
module tb_app_read_arbiter;

  logic xclk;
  logic reset;
  int   checks;
  int   errors;

  app_read_arbiter_if #(.NUM_APPS(4)) bus ();

  app_read_arbiter #(
    .NUM_APPS    (4),
    .HOLD_CYCLES (3),
    .TURN_CYCLES (1)
  ) dut (
    .xclk  (xclk),
    .reset (reset),
    .bus   (bus)
  );

  initial xclk = 1'b0;
  always #5 xclk = ~xclk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one directed read over a 24-edge window. The strobe is sampled high
  // at edges [0,len1) and [start2,start2+len2); clear_collision and reset are
  // high at edges clr_at and rst_at. With scramble set, App words and claims
  // are inverted right after the latch edge. probe_word is db_out after edge
  // probe_at.
  task automatic applyStimulus(input logic [3:0] avail, input logic [63:0] words,
                               input int len1, input int start2, input int len2,
                               input int clr_at, input int rst_at,
                               input bit scramble, input int probe_at,
                               output logic [31:0] en_mask,
                               output logic [31:0] done_mask,
                               output logic [31:0] nores_mask,
                               output logic [15:0] probe_word);
    int n;
    en_mask    = '0;
    done_mask  = '0;
    nores_mask = '0;
    probe_word = '0;
    bus.data_avail_app  = avail;
    bus.db_out_app      = words;
    bus.read_qualified  = (len1 > 0);
    bus.clear_collision = (clr_at == 0);
    reset               = (rst_at == 0);
    for (int k = 0; k < 24; k++) begin
      @(posedge xclk);
      #1;
      en_mask[k]    = bus.db_out_en;
      done_mask[k]  = bus.read_done;
      nores_mask[k] = bus.no_responder;
      if (k == probe_at) probe_word = bus.db_out;
      n = k + 1;
      bus.read_qualified  = (n < len1) || ((n >= start2) && (n < start2 + len2));
      bus.clear_collision = (n == clr_at);
      reset               = (n == rst_at);
      if (scramble && (k == 1)) begin
        bus.data_avail_app = ~avail;
        bus.db_out_app     = ~words;
      end
    end
    bus.read_qualified  = 1'b0;
    bus.clear_collision = 1'b0;
    reset               = 1'b0;
  endtask

  logic [31:0] en_m;
  logic [31:0] done_m;
  logic [31:0] nores_m;
  logic [15:0] word;

  localparam logic [63:0] W_SINGLE = 64'h4444_1503_2222_1111;
  localparam logic [63:0] W_COLL   = 64'h5555_3333_2222_AAAA;
  localparam logic [63:0] W_MISC   = 64'h7777_0000_2222_0BB0;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.read_qualified  = 1'b0;
    bus.db_out_app      = '0;
    bus.data_avail_app  = '0;
    bus.clear_collision = 1'b0;
    repeat (3) @(posedge xclk);
    #1;
    checkOutput("rst_db_out", 32'(bus.db_out), 32'h0000);
    checkOutput("rst_en", 32'(bus.db_out_en), 32'd0);
    checkOutput("rst_done", 32'(bus.read_done), 32'd0);
    checkOutput("rst_nores", 32'(bus.no_responder), 32'd0);
    checkOutput("rst_coll", 32'(bus.collision), 32'd0);
    checkOutput("rst_count", 32'(bus.collision_count), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge xclk);
    #1;

    // App2 alone claims; strobe drops right after the latch edge.
    // Drive after edges 1..3, read_done after edge 4; inputs scrambled mid-drive.
    applyStimulus(4'b0100, W_SINGLE, 2, -1, 0, -1, -1, 1'b1, 3, en_m, done_m, nores_m, word);
    checkOutput("single_en", en_m, 32'h0000_000E);
    checkOutput("single_done", done_m, 32'h0000_0010);
    checkOutput("single_nores", nores_m, 32'h0);
    checkOutput("single_word", 32'(word), 32'h1503);
    checkOutput("single_coll", 32'(bus.collision), 32'd0);

    // Strobe held for 6 samples: drive extends to edge 5, TURN after edge 6.
    applyStimulus(4'b0010, W_MISC, 6, -1, 0, -1, -1, 1'b0, 1, en_m, done_m, nores_m, word);
    checkOutput("long_en", en_m, 32'h0000_003E);
    checkOutput("long_done", done_m, 32'h0000_0040);
    checkOutput("long_word", 32'(word), 32'h2222);

    // Nobody claims: all-ones word and a no_responder pulse after the latch edge.
    applyStimulus(4'b0000, W_MISC, 2, -1, 0, -1, -1, 1'b0, 1, en_m, done_m, nores_m, word);
    checkOutput("nores_en", en_m, 32'h0000_000E);
    checkOutput("nores_done", done_m, 32'h0000_0010);
    checkOutput("nores_pulse", nores_m, 32'h0000_0002);
    checkOutput("nores_word", 32'(word), 32'hFFFF);

    // App0 and App3 both claim: App0 wins and the collision is recorded.
    applyStimulus(4'b1001, W_COLL, 2, -1, 0, -1, -1, 1'b0, 1, en_m, done_m, nores_m, word);
    checkOutput("coll_en", en_m, 32'h0000_000E);
    checkOutput("coll_word", 32'(word), 32'hAAAA);
    checkOutput("coll_flag", 32'(bus.collision), 32'd1);
    checkOutput("coll_count1", 32'(bus.collision_count), 32'd1);

    // 255 more collided reads: 256 in total, count saturates at 255.
    for (int r = 0; r < 255; r++) begin
      applyStimulus(4'b1001, W_COLL, 2, -1, 0, -1, -1, 1'b0, 1, en_m, done_m, nores_m, word);
    end
    checkOutput("coll_count_sat", 32'(bus.collision_count), 32'd255);

    // Lone clear pulse with no read.
    applyStimulus(4'b0000, W_MISC, 0, -1, 0, 0, -1, 1'b0, 1, en_m, done_m, nores_m, word);
    checkOutput("clear_flag", 32'(bus.collision), 32'd0);
    checkOutput("clear_count", 32'(bus.collision_count), 32'd0);

    // One collision, then a collision whose latch edge meets a clear pulse.
    applyStimulus(4'b1001, W_COLL, 2, -1, 0, -1, -1, 1'b0, 1, en_m, done_m, nores_m, word);
    checkOutput("coll_again_count", 32'(bus.collision_count), 32'd1);
    applyStimulus(4'b1001, W_COLL, 2, -1, 0, 1, -1, 1'b0, 1, en_m, done_m, nores_m, word);
    checkOutput("clear_wins_flag", 32'(bus.collision), 32'd0);
    checkOutput("clear_wins_count", 32'(bus.collision_count), 32'd0);

    // Strobe drops while in WAIT: nothing driven, db_out keeps 16'hAAAA.
    applyStimulus(4'b0000, W_MISC, 1, -1, 0, -1, -1, 1'b0, 3, en_m, done_m, nores_m, word);
    checkOutput("abort_en", en_m, 32'h0);
    checkOutput("abort_done", done_m, 32'h0);
    checkOutput("abort_nores", nores_m, 32'h0);
    checkOutput("abort_word", 32'(word), 32'hAAAA);

    // New start sampled at edge 5 (TURN): IDLE after 5, WAIT after 6,
    // second drive after edges 7..9, second read_done after edge 10.
    applyStimulus(4'b0001, W_MISC, 2, 5, 3, -1, -1, 1'b0, 8, en_m, done_m, nores_m, word);
    checkOutput("b2b_en", en_m, 32'h0000_038E);
    checkOutput("b2b_done", done_m, 32'h0000_0410);
    checkOutput("b2b_word", 32'(word), 32'h0BB0);

    // Reset sampled at edge 3 (hold count 1): drive stops, db_out clears.
    applyStimulus(4'b1000, W_MISC, 3, -1, 0, -1, 3, 1'b0, 3, en_m, done_m, nores_m, word);
    checkOutput("rdrive_en", en_m, 32'h0000_0006);
    checkOutput("rdrive_done", done_m, 32'h0);
    checkOutput("rdrive_word", 32'(word), 32'h0000);

    // A normal read afterwards shows the block came back to IDLE.
    applyStimulus(4'b0100, W_SINGLE, 2, -1, 0, -1, -1, 1'b1, 3, en_m, done_m, nores_m, word);
    checkOutput("post_rst_en", en_m, 32'h0000_000E);
    checkOutput("post_rst_word", 32'(word), 32'h1503);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
